// File: rtl/red_pitaya_signal_router.sv
// ---------------------------------------------------------------------------
// red_pitaya_signal_router
// Routes N_SRC signed sample streams to N_DST destinations through a per-
// destination select register. It also builds N_DAC saturated sums of any
// masked subset of the sources using a pipelined adder tree.
// Ports:
//   clk_i, rst_i        processing clock, async active-high reset
//   src_dat_i           N_SRC packed sources, source s at [s*DW +: DW]
//   dst_dat_o           N_DST routed samples (1 cycle latency)
//   dac_dat_o           N_DAC saturated sums (L+2 cycles latency)
//   sys_*               register bus, ack one cycle after wen|ren
// ---------------------------------------------------------------------------
module red_pitaya_signal_router #(
  parameter int N_SRC = 16,
  parameter int N_DST = 10,
  parameter int N_DAC = 2,
  parameter int DW    = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC*DW-1:0]    src_dat_i,
  output logic [N_DST*DW-1:0]    dst_dat_o,
  output logic [N_DAC*DW-1:0]    dac_dat_o,
  input  logic [31:0]            sys_addr,
  input  logic [31:0]            sys_wdata,
  input  logic                   sys_wen,
  input  logic                   sys_ren,
  output logic [31:0]            sys_rdata,
  output logic                   sys_ack,
  output logic                   sys_err
);

  localparam int SW = $clog2(N_SRC);
  localparam int L  = $clog2(N_SRC);
  localparam int NP = 1 << L;   // leaves, padded to a power of two
  localparam int TW = DW + L;   // tree width, wide enough for the full sum

  localparam logic signed [TW-1:0] SAT_MAX = TW'((2 ** (DW - 1)) - 1);
  localparam logic signed [TW-1:0] SAT_MIN = TW'(-(2 ** (DW - 1)));

  logic signed [DW-1:0] src [N_SRC];
  logic [SW-1:0]        sel_q  [N_DST];
  logic [N_DAC-1:0]     mask_q [N_SRC];
  logic [N_DAC-1:0]     flag_q;
  logic [15:0]          cnt_q  [N_DAC];

  // Heap-ordered tree: node n = node 2n + node 2n+1, leaves at NP..2NP-1, root at 1.
  logic signed [TW-1:0] node_q [N_DAC][1:2*NP-1];

  logic [N_DAC-1:0]     sat_evt;
  logic [DW-1:0]        sat_val [N_DAC];

  logic [7:0]           idx;
  logic [5:0]           kidx;
  logic                 hit_sel, hit_mask, hit_flag, hit_cnt;
  logic                 dec_err, bad_sel, acc;
  logic [31:0]          rd_val;
  logic [N_DAC-1:0]     flag_clr;
  logic [N_DAC-1:0]     cnt_clr;

  logic unused_addr;
  assign unused_addr = ^{sys_addr[31:12], sys_addr[1:0]};

  always_comb begin
    for (int s = 0; s < N_SRC; s++) src[s] = src_dat_i[s*DW +: DW];
  end

  // Clamp the tree root; sat_evt is high in the cycle the clamped value is registered.
  always_comb begin
    for (int k = 0; k < N_DAC; k++) begin
      sat_evt[k] = 1'b0;
      sat_val[k] = node_q[k][1][DW-1:0];
      if (node_q[k][1] > SAT_MAX) begin
        sat_evt[k] = 1'b1;
        sat_val[k] = SAT_MAX[DW-1:0];
      end else if (node_q[k][1] < SAT_MIN) begin
        sat_evt[k] = 1'b1;
        sat_val[k] = SAT_MIN[DW-1:0];
      end
    end
  end

  // Bus address decode
  always_comb begin
    idx      = sys_addr[9:2];
    kidx     = sys_addr[7:2];
    hit_sel  = 1'b0;
    hit_mask = 1'b0;
    hit_flag = 1'b0;
    hit_cnt  = 1'b0;
    rd_val   = '0;
    case (sys_addr[11:10])
      2'b00:   hit_sel  = (int'(idx) < N_DST);
      2'b01:   hit_mask = (int'(idx) < N_SRC);
      default: begin
        if (sys_addr[11:0] == 12'h800) hit_flag = 1'b1;
        else if (sys_addr[11:8] == 4'h9 && int'(kidx) < N_DAC) hit_cnt = 1'b1;
      end
    endcase
    dec_err = !(hit_sel || hit_mask || hit_flag || hit_cnt);
    bad_sel = sys_wen && hit_sel && (sys_wdata >= 32'(N_SRC));
    acc     = sys_wen || sys_ren;
    for (int d = 0; d < N_DST; d++)
      if (hit_sel && int'(idx) == d) rd_val = 32'(sel_q[d]);
    for (int s = 0; s < N_SRC; s++)
      if (hit_mask && int'(idx) == s) rd_val = 32'(mask_q[s]);
    if (hit_flag) rd_val = 32'(flag_q);
    for (int k = 0; k < N_DAC; k++)
      if (hit_cnt && int'(kidx) == k) rd_val = 32'(cnt_q[k]);
    flag_clr = (sys_wen && hit_flag) ? sys_wdata[N_DAC-1:0] : '0;
    for (int k = 0; k < N_DAC; k++)
      cnt_clr[k] = sys_wen && hit_cnt && (int'(kidx) == k);
  end

  // Configuration, status and bus response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int d = 0; d < N_DST; d++) sel_q[d] <= SW'(d % N_SRC);
      for (int s = 0; s < N_SRC; s++) mask_q[s] <= '0;
      for (int k = 0; k < N_DAC; k++) cnt_q[k] <= '0;
      flag_q    <= '0;
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= acc;
      sys_err   <= acc && (dec_err || bad_sel);
      // rdata is sampled before the write lands, so wen+ren returns the old value
      sys_rdata <= (acc && !dec_err) ? rd_val : '0;
      for (int d = 0; d < N_DST; d++)
        if (sys_wen && hit_sel && !bad_sel && int'(idx) == d)
          sel_q[d] <= sys_wdata[SW-1:0];
      for (int s = 0; s < N_SRC; s++)
        if (sys_wen && hit_mask && int'(idx) == s)
          mask_q[s] <= sys_wdata[N_DAC-1:0];
      // a saturation event overrides a simultaneous clear
      flag_q <= (flag_q & ~flag_clr) | sat_evt;
      for (int k = 0; k < N_DAC; k++) begin
        if (cnt_clr[k])
          cnt_q[k] <= sat_evt[k] ? 16'd1 : 16'd0;
        else if (sat_evt[k] && cnt_q[k] != 16'hFFFF)
          cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  // Routing and summing datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst_dat_o <= '0;
      dac_dat_o <= '0;
      for (int k = 0; k < N_DAC; k++)
        for (int n = 1; n < 2 * NP; n++) node_q[k][n] <= '0;
    end else begin
      for (int d = 0; d < N_DST; d++)
        dst_dat_o[d*DW +: DW] <= src[sel_q[d]];
      for (int k = 0; k < N_DAC; k++) begin
        for (int s = 0; s < N_SRC; s++)
          node_q[k][NP+s] <= mask_q[s][k] ? {{L{src[s][DW-1]}}, src[s]} : '0;
        for (int s = N_SRC; s < NP; s++)
          node_q[k][NP+s] <= '0;
        for (int n = 1; n < NP; n++)
          node_q[k][n] <= node_q[k][2*n] + node_q[k][2*n+1];
        dac_dat_o[k*DW +: DW] <= sat_val[k];
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_signal_router.sv
module tb_red_pitaya_signal_router;

  localparam int N_SRC = 16;
  localparam int N_DST = 10;
  localparam int N_DAC = 2;
  localparam int DW    = 14;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [N_SRC*DW-1:0]   src_dat_i = '0;
  logic [N_DST*DW-1:0]   dst_dat_o;
  logic [N_DAC*DW-1:0]   dac_dat_o;
  logic [31:0]           sys_addr = '0;
  logic [31:0]           sys_wdata = '0;
  logic                  sys_wen = 1'b0;
  logic                  sys_ren = 1'b0;
  logic [31:0]           sys_rdata;
  logic                  sys_ack;
  logic                  sys_err;

  int vectors = 0;
  int miscompares = 0;

  red_pitaya_signal_router #(
    .N_SRC(N_SRC), .N_DST(N_DST), .N_DAC(N_DAC), .DW(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .src_dat_i(src_dat_i), .dst_dat_o(dst_dat_o), .dac_dat_o(dac_dat_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] dst(input int d);
    return 32'(dst_dat_o[d*DW +: DW]);
  endfunction

  function automatic logic [31:0] dac(input int k);
    return 32'(dac_dat_o[k*DW +: DW]);
  endfunction

  task automatic set_src(input int s, input logic [DW-1:0] v);
    src_dat_i[s*DW +: DW] = v;
  endtask

  task automatic bus_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    tick();
    sys_wen = 1'b0;
    chk({tag, "_ack"}, 32'(sys_ack), 32'd1);
    chk({tag, "_err"}, 32'(sys_err), 32'(exp_err));
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic exp_err);
    sys_addr = a; sys_ren = 1'b1;
    tick();
    sys_ren = 1'b0;
    chk({tag, "_ack"}, 32'(sys_ack), 32'd1);
    chk({tag, "_err"}, 32'(sys_err), 32'(exp_err));
    chk({tag, "_rdata"}, sys_rdata, exp_d);
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_dst", 32'(|dst_dat_o), 32'd0);
    chk("rst_dac", 32'(|dac_dat_o), 32'd0);
    chk("rst_ack", 32'(sys_ack), 32'd0);
    rst_i = 1'b0;
    tick();
    bus_rd("rd_sel9_rst", 32'h024, 32'd9, 1'b0);
    bus_rd("rd_mask5_rst", 32'h414, 32'd0, 1'b0);

    // routing: sel[3]=9
    set_src(9, 14'h0123);
    set_src(5, 14'h1555);
    tick();
    chk("dst5_default", dst(5), 32'h1555);
    chk("dst3_before", dst(3), 32'h0);
    bus_wr("wr_sel3", 32'h00C, 32'd9, 1'b0);
    tick();
    chk("dst3_routed", dst(3), 32'h0123);
    bus_rd("rd_sel3", 32'h00C, 32'd9, 1'b0);

    // sum latency: src0+src1 to DAC0
    bus_wr("wr_mask0", 32'h400, 32'd1, 1'b0);
    bus_wr("wr_mask1", 32'h404, 32'd1, 1'b0);
    set_src(0, 14'd100);
    set_src(1, 14'(-30));
    tick(5);
    chk("dac0_t5", dac(0), 32'd0);
    tick();
    chk("dac0_t6", dac(0), 32'd70);
    chk("dac1_t6", dac(1), 32'd0);
    set_src(0, '0);
    set_src(1, '0);

    // positive saturation on DAC1 for 10 samples
    bus_wr("wr_mask0b", 32'h400, 32'd2, 1'b0);
    bus_wr("wr_mask1b", 32'h404, 32'd2, 1'b0);
    bus_wr("wr_mask2b", 32'h408, 32'd2, 1'b0);
    bus_wr("wr_mask3b", 32'h40C, 32'd2, 1'b0);
    tick(6);
    chk("dac0_idle", dac(0), 32'd0);
    chk("dac1_idle", dac(1), 32'd0);
    for (int s = 0; s < 4; s++) set_src(s, 14'h1000);
    tick(6);
    chk("dac1_satpos", dac(1), 32'h1FFF);
    tick(4);
    for (int s = 0; s < 4; s++) set_src(s, '0);
    tick(8);
    chk("dac1_drained", dac(1), 32'd0);
    bus_rd("rd_flags", 32'h800, 32'd2, 1'b0);
    bus_rd("rd_cnt1", 32'h904, 32'd10, 1'b0);
    bus_rd("rd_cnt0", 32'h900, 32'd0, 1'b0);
    bus_wr("wr_flagclr", 32'h800, 32'd2, 1'b0);
    bus_rd("rd_flags_clr", 32'h800, 32'd0, 1'b0);

    // negative saturation, single sample
    for (int s = 0; s < 4; s++) set_src(s, 14'h3000);
    tick();
    for (int s = 0; s < 4; s++) set_src(s, '0);
    tick(5);
    chk("dac1_satneg", dac(1), 32'h2000);
    tick();
    chk("dac1_after_neg", dac(1), 32'd0);
    bus_rd("rd_cnt1_neg", 32'h904, 32'd11, 1'b0);
    bus_wr("wr_flagclr2", 32'h800, 32'd3, 1'b0);

    // counter clear in the same cycle as a saturating sample reaches the output
    for (int s = 0; s < 4; s++) set_src(s, 14'h1000);
    tick();
    for (int s = 0; s < 4; s++) set_src(s, '0);
    tick(4);
    bus_wr("wr_cntclr_sat", 32'h904, 32'd0, 1'b0);
    chk("dac1_sat_at_clr", dac(1), 32'h1FFF);
    bus_rd("rd_cnt1_setwins", 32'h904, 32'd1, 1'b0);
    bus_rd("rd_flag_setwins", 32'h800, 32'd2, 1'b0);
    bus_wr("wr_cntclr", 32'h904, 32'hFFFF_FFFF, 1'b0);
    bus_rd("rd_cnt1_cleared", 32'h904, 32'd0, 1'b0);

    // bus errors
    bus_wr("wr_sel2_bad", 32'h008, 32'd16, 1'b1);
    bus_rd("rd_sel2", 32'h008, 32'd2, 1'b0);
    bus_rd("rd_unmapped", 32'hFFC, 32'd0, 1'b1);
    bus_rd("rd_sel10", 32'h028, 32'd0, 1'b1);
    bus_wr("wr_mask16", 32'h440, 32'd3, 1'b1);
    bus_rd("rd_cnt2", 32'h908, 32'd0, 1'b1);

    // wen and ren together: write, returning the old value
    sys_addr = 32'h41C; sys_wdata = 32'd3; sys_wen = 1'b1; sys_ren = 1'b1;
    tick();
    sys_wen = 1'b0; sys_ren = 1'b0;
    chk("wrrd_ack", 32'(sys_ack), 32'd1);
    chk("wrrd_rdata_old", sys_rdata, 32'd0);
    bus_rd("rd_mask7", 32'h41C, 32'd3, 1'b0);

    // asynchronous reset mid-stream
    set_src(0, 14'h1000);
    tick(8);
    chk("dst0_live", dst(0), 32'h1000);
    chk("dac1_live", dac(1), 32'h1000);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_dst", 32'(|dst_dat_o), 32'd0);
    chk("arst_dac", 32'(|dac_dat_o), 32'd0);
    chk("arst_ack", 32'(sys_ack), 32'd0);
    chk("arst_rdata", sys_rdata, 32'd0);
    tick();
    rst_i = 1'b0;
    // N_DST is 10 at defaults, so the highest select register checked is sel[9]
    bus_rd("rd_sel9_arst", 32'h024, 32'd9, 1'b0);
    bus_rd("rd_sel3_arst", 32'h00C, 32'd3, 1'b0);
    bus_rd("rd_mask0_arst", 32'h400, 32'd0, 1'b0);
    bus_rd("rd_mask7_arst", 32'h41C, 32'd0, 1'b0);

    // mask change takes effect on the sample after the ack
    bus_wr("wr_mask0_post", 32'h400, 32'd1, 1'b0);
    tick(5);
    chk("dac0_post_t5", dac(0), 32'd0);
    tick();
    chk("dac0_post_t6", dac(0), 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
